// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped line cache.
package cache_pkg;

  localparam int DEF_INDEX_W = 3;
  localparam int PROC_ADDR_W = 30;
  localparam int OFFSET_W    = 2;
  localparam int DEF_TAG_W   = PROC_ADDR_W - OFFSET_W - DEF_INDEX_W;
  localparam int WORD_W      = 32;
  localparam int LINE_W      = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_ALLOC = 2'd2
  } state_e;

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage for every cache line: one asynchronous read port,
// a word write that marks the line dirty and a full-line fill that marks it clean.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                srst_i,
  input  logic [INDEX_W-1:0]  rd_idx_i,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [LINE_W-1:0]   rd_data_o,
  input  logic                word_we_i,
  input  logic [INDEX_W-1:0]  word_idx_i,
  input  logic [OFFSET_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]   word_data_i,
  input  logic                fill_we_i,
  input  logic [INDEX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [LINE_W-1:0]   fill_data_i
);

  localparam int NUM_BLOCKS = 2 ** INDEX_W;

  logic [NUM_BLOCKS-1:0] valid_vec;
  logic [NUM_BLOCKS-1:0] dirty_vec;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  // Only the status bits are reset; tag/data contents are meaningless until a fill.
  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_line
    logic valid_q;
    logic dirty_q;

    always_ff @(posedge clk) begin
      if (srst_i) begin
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
      end else if (fill_we_i && fill_idx_i == INDEX_W'(gi)) begin
        valid_q <= 1'b1;
        dirty_q <= 1'b0;
      end else if (word_we_i && word_idx_i == INDEX_W'(gi)) begin
        dirty_q <= 1'b1;
      end
    end

    assign valid_vec[gi] = valid_q;
    assign dirty_vec[gi] = dirty_q;
  end

  always_ff @(posedge clk) begin
    if (fill_we_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (word_we_i) begin
      data_q[word_idx_i][{word_sel_i, 5'd0} +: WORD_W] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_vec[rd_idx_i];
  assign rd_dirty_o = dirty_vec[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate cache: combinational hits, stalls the
// processor on a miss while the dirty victim is written back and the line fetched.
module dcache_direct_mapped
  import cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic                     proc_read,
  input  logic                     proc_write,
  input  logic [PROC_ADDR_W-1:0]   proc_addr,
  input  logic [WORD_W-1:0]        proc_wdata,
  output logic [WORD_W-1:0]        proc_rdata,
  output logic                     proc_stall,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);

  localparam int TAG_LSB = OFFSET_W + INDEX_W;

  logic [OFFSET_W-1:0] req_word;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                request;
  logic                hit;

  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [LINE_W-1:0]   line_data;

  logic                word_we;
  logic                fill_we;

  state_e                   state_q;
  logic                     mem_read_q;
  logic                     mem_write_q;
  logic [TAG_W+INDEX_W-1:0] mem_addr_q;
  logic [LINE_W-1:0]        mem_wdata_q;

  assign req_word = proc_addr[OFFSET_W-1:0];
  assign req_idx  = proc_addr[TAG_LSB-1:OFFSET_W];
  assign req_tag  = proc_addr[PROC_ADDR_W-1:TAG_LSB];
  assign request  = proc_read | proc_write;
  assign hit      = line_valid && (line_tag == req_tag);

  // Reset outranks any write or fill that happens to coincide with it.
  assign word_we = !proc_reset && (state_q == ST_IDLE) && proc_write && hit;
  assign fill_we = !proc_reset && (state_q == ST_ALLOC) && mem_ready;

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk         (clk),
    .srst_i      (proc_reset),
    .rd_idx_i    (req_idx),
    .rd_valid_o  (line_valid),
    .rd_dirty_o  (line_dirty),
    .rd_tag_o    (line_tag),
    .rd_data_o   (line_data),
    .word_we_i   (word_we),
    .word_idx_i  (req_idx),
    .word_sel_i  (req_word),
    .word_data_i (proc_wdata),
    .fill_we_i   (fill_we),
    .fill_idx_i  (req_idx),
    .fill_tag_i  (req_tag),
    .fill_data_i (mem_rdata)
  );

  assign proc_stall = (state_q != ST_IDLE) || (request && !hit);
  assign proc_rdata = (proc_read && !proc_stall) ? line_data[{req_word, 5'd0} +: WORD_W] : '0;

  // The processor holds the request stable while stalled, so the fetch address can be
  // taken from proc_addr when entering ALLOC and still be registered, not combinational.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (request && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= ST_WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {line_tag, req_idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= ST_ALLOC;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag, req_idx};
            end
          end
        end
        ST_WB: begin
          if (mem_ready) begin
            state_q     <= ST_ALLOC;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {req_tag, req_idx};
            mem_wdata_q <= '0;
          end
        end
        ST_ALLOC: begin
          if (mem_ready) begin
            state_q    <= ST_IDLE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench: a line-level cache model predicts processor responses and
// memory transactions; independent monitors compare them against the DUT.
module tb_dcache_direct_mapped;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  dcache_direct_mapped dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    bit           is_write;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    bit          miss;
    logic [29:0] addr;
  } proc_exp_t;

  mem_exp_t  mexp[$];
  proc_exp_t pexp[$];
  int checks = 0;
  int errors = 0;

  // reference cache and two backing stores (model view and what the DUT actually wrote)
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [31:0]  m_data  [8][4];
  logic [127:0] ref_mem [int];
  logic [127:0] dev_mem [int];

  int lat_cfg = 5;
  int wr_txn = 0;
  int rd_txn = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(int key);
    logic [127:0] l;
    if (key == 1) return {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'(key * 4 + k) * 32'h9E3779B1;
    return l;
  endfunction

  function automatic logic [127:0] ref_get(int key);
    if (ref_mem.exists(key)) return ref_mem[key];
    return init_line(key);
  endfunction

  function automatic logic [127:0] dev_get(int key);
    if (dev_mem.exists(key)) return dev_mem[key];
    return init_line(key);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic [29:0] addr, input bit wr, input logic [31:0] wdata,
                              output bit miss, output logic [31:0] exp_rd);
    int idx;
    int w;
    logic [24:0]  tag;
    logic [127:0] line;
    mem_exp_t     me;
    idx  = int'(addr[4:2]);
    w    = int'(addr[1:0]);
    tag  = addr[29:5];
    miss = !(m_valid[idx] && m_tag[idx] == tag);
    if (miss) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) line[k*32 +: 32] = m_data[idx][k];
        me.is_write = 1'b1;
        me.addr     = {m_tag[idx], 3'(idx)};
        me.wdata    = line;
        mexp.push_back(me);
        ref_mem[int'(me.addr)] = line;
      end
      me.is_write = 1'b0;
      me.addr     = {tag, 3'(idx)};
      me.wdata    = '0;
      mexp.push_back(me);
      line = ref_get(int'(me.addr));
      for (int k = 0; k < 4; k++) m_data[idx][k] = line[k*32 +: 32];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    exp_rd = m_data[idx][w];
    if (wr) begin
      m_data[idx][w] = wdata;
      m_dirty[idx]   = 1'b1;
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic do_req(input logic [29:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata, output int cycles);
    proc_exp_t pe;
    bit        miss;
    logic [31:0] exp_rd;
    bit        done;
    model_access(addr, wr, wdata, miss, exp_rd);
    pe.is_read = rd && !wr;
    pe.rdata   = exp_rd;
    pe.miss    = miss;
    pe.addr    = addr;
    pexp.push_back(pe);
    @(posedge clk);
    #1;
    proc_addr  = addr;
    proc_read  = rd;
    proc_write = wr;
    proc_wdata = wdata;
    cycles = 0;
    done   = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (!proc_stall) done = 1'b1;
      else cycles++;
    end
    if (!done) begin
      errors++;
      $display("FAIL req_timeout: addr %0h still stalled after 500 cycles", addr);
      finish_now();
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // processor-side monitor
  bit stall_seen = 1'b0;
  always @(negedge clk) begin
    proc_exp_t e;
    if (proc_reset) begin
      stall_seen = 1'b0;
    end else if (proc_read || proc_write) begin
      if (proc_stall) begin
        stall_seen = 1'b1;
      end else begin
        if (pexp.size() == 0) begin
          chk("proc_unexpected_completion", {98'd0, proc_addr}, 128'hFFFF);
        end else begin
          e = pexp.pop_front();
          chk("proc_miss_flag", {127'd0, stall_seen}, {127'd0, e.miss});
          if (e.is_read) chk("proc_rdata", {96'd0, proc_rdata}, {96'd0, e.rdata});
          $display("proc %s addr=%0h miss=%0d rdata=%0h", e.is_read ? "RD" : "WR",
                   e.addr, stall_seen, proc_rdata);
        end
        stall_seen = 1'b0;
      end
    end
  end

  // memory responder and memory-side monitor
  bit           busy = 1'b0;
  int           cnt;
  bit           cur_w;
  logic [27:0]  cur_addr;
  logic [127:0] cur_wdata;
  always @(negedge clk) begin
    mem_exp_t e;
    int lat;
    chk("mem_rd_wr_exclusive", {127'd0, mem_read && mem_write}, 128'd0);
    if (mem_ready) begin
      mem_ready = 1'b0;
      busy      = 1'b0;
    end else if (busy && !mem_read && !mem_write) begin
      busy = 1'b0;
    end
    if (!busy && (mem_read || mem_write)) begin
      if (mexp.size() == 0) begin
        chk("mem_unexpected_txn", {100'd0, mem_addr}, 128'hFFFF_FFFF);
      end else begin
        e = mexp.pop_front();
        chk("mem_txn_is_write", {127'd0, mem_write}, {127'd0, e.is_write});
        chk("mem_txn_addr", {100'd0, mem_addr}, {100'd0, e.addr});
        if (e.is_write) chk("mem_txn_wdata", mem_wdata, e.wdata);
      end
      cur_w     = mem_write;
      cur_addr  = mem_addr;
      cur_wdata = mem_wdata;
      if (mem_write) begin
        dev_mem[int'(mem_addr)] = mem_wdata;
        wr_txn++;
      end else begin
        rd_txn++;
      end
      $display("mem %s addr=%0h", mem_write ? "WB" : "FETCH", mem_addr);
      lat  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      cnt  = lat;
      busy = 1'b1;
    end else if (busy) begin
      chk("mem_hold_addr", {100'd0, mem_addr}, {100'd0, cur_addr});
      chk("mem_hold_kind", {126'd0, mem_write, mem_read}, {126'd0, cur_w, !cur_w});
      if (cur_w) chk("mem_hold_wdata", mem_wdata, cur_wdata);
    end
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        mem_ready = 1'b1;
        if (!cur_w) mem_rdata = dev_get(int'(cur_addr));
      end
    end
  end

  initial begin
    int cyc;
    int wb0;
    int rd0;
    logic [24:0] tag;
    logic [29:0] addr;
    int op;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
    chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    chk("rst_stall", {127'd0, proc_stall}, 128'd0);
    @(posedge clk);
    #1 proc_reset = 1'b0;

    // clean compulsory miss, then hit in the fetched line
    lat_cfg = 5;
    do_req(30'h4, 1'b1, 1'b0, '0, cyc);
    chk("t1_stall_cycles", 128'(cyc), 128'd6);
    chk("t1_rdata", {96'd0, proc_rdata}, {96'd0, 32'h11111111});
    chk("t1_mem_read_low", {127'd0, mem_read}, 128'd0);
    do_req(30'h5, 1'b1, 1'b0, '0, cyc);
    chk("t2_stall_cycles", 128'(cyc), 128'd0);
    chk("t2_rdata", {96'd0, proc_rdata}, {96'd0, 32'h22222222});
    chk("t2_mem_idle", {126'd0, mem_read, mem_write}, 128'd0);

    // dirty conflict miss: writeback then fetch
    do_req(30'h4, 1'b0, 1'b1, 32'hDEADBEEF, cyc);
    chk("t3_write_hit_cycles", 128'(cyc), 128'd0);
    wb0 = wr_txn;
    do_req(30'h24, 1'b1, 1'b0, '0, cyc);
    chk("t3_stall_cycles", 128'(cyc), 128'd11);
    chk("t3_wb_count", 128'(wr_txn - wb0), 128'd1);

    // clean conflict misses: no writeback
    wb0 = wr_txn;
    do_req(30'h4, 1'b1, 1'b0, '0, cyc);
    chk("t4a_stall_cycles", 128'(cyc), 128'd6);
    chk("t4a_rdata", {96'd0, proc_rdata}, {96'd0, 32'hDEADBEEF});
    do_req(30'h24, 1'b1, 1'b0, '0, cyc);
    chk("t4b_stall_cycles", 128'(cyc), 128'd6);
    chk("t4_wb_count", 128'(wr_txn - wb0), 128'd0);

    // reset during ALLOC abandons the fetch and invalidates all lines
    idle(2);
    lat_cfg = 10;
    begin
      mem_exp_t me;
      me.is_write = 1'b0;
      me.addr     = 28'h2;
      me.wdata    = '0;
      mexp.push_back(me);
    end
    @(posedge clk);
    #1;
    proc_addr = 30'h8;
    proc_read = 1'b1;
    @(negedge clk);
    chk("t5_stall_detect", {127'd0, proc_stall}, 128'd1);
    @(negedge clk);
    chk("t5_alloc_mem_read", {127'd0, mem_read}, 128'd1);
    @(posedge clk);
    #1;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    @(posedge clk);
    #1 proc_reset = 1'b0;
    @(negedge clk);
    chk("t5_mem_read_after_rst", {127'd0, mem_read}, 128'd0);
    chk("t5_mem_write_after_rst", {127'd0, mem_write}, 128'd0);
    chk("t5_stall_after_rst", {127'd0, proc_stall}, 128'd0);
    model_reset();
    do_req(30'h8, 1'b1, 1'b0, '0, cyc);
    chk("t5_refetch_cycles", 128'(cyc), 128'd11);
    do_req(30'h24, 1'b1, 1'b0, '0, cyc);
    chk("t5_line1_invalid", 128'(cyc), 128'd11);

    // long memory latency on both writeback and fetch
    lat_cfg = 20;
    do_req(30'h40, 1'b0, 1'b1, 32'hCAFEF00D, cyc);
    chk("t6_alloc_cycles", 128'(cyc), 128'd21);
    wb0 = wr_txn;
    rd0 = rd_txn;
    do_req(30'h0, 1'b1, 1'b0, '0, cyc);
    chk("t6_stall_cycles", 128'(cyc), 128'd41);
    chk("t6_wb_count", 128'(wr_txn - wb0), 128'd1);
    chk("t6_fetch_count", 128'(rd_txn - rd0), 128'd1);

    // random traffic over a few tags per index
    lat_cfg = -1;
    for (int n = 0; n < 400; n++) begin
      tag = 25'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) tag = tag | 25'h1000000;
      addr = {tag, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = int'($urandom_range(0, 9));
      if (op < 5)      do_req(addr, 1'b1, 1'b0, '0, cyc);
      else if (op < 9) do_req(addr, 1'b0, 1'b1, $urandom, cyc);
      else             do_req(addr, 1'b1, 1'b1, $urandom, cyc);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(5);
    chk("proc_queue_drained", 128'(pexp.size()), 128'd0);
    chk("mem_queue_drained", 128'(mexp.size()), 128'd0);
    finish_now();
  end

endmodule
